// File: rtl/bg_mosaic_apply.sv
// BG mosaic apply: owns $2106, holds blocky pixels and adjusts fetch rows.
// Optional debug readback port reg_rdata under MOSAIC_READBACK_EN.
module bg_mosaic_apply #(
  parameter int NUM_BG = 4,
  parameter int PIX_W  = 12,
  parameter int Y_W    = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dot_en,
  input  logic                    reg_we,
  input  logic [7:0]              reg_wdata,
  output logic [3:0]              size,
  input  logic                    pixel_strobe,
  input  logic [3:0]              y_subtract,
  input  logic [Y_W-1:0]          vcount,
  input  logic [NUM_BG*PIX_W-1:0] bg_pixel_in,
  output logic [NUM_BG*PIX_W-1:0] bg_pixel_out,
  output logic [NUM_BG*Y_W-1:0]   bg_y_out
`ifdef MOSAIC_READBACK_EN
  ,
  output logic [7:0]              reg_rdata
`endif
);

  logic [3:0]                    size_q, size_d;
  logic [NUM_BG-1:0]             en_q, en_d;
  logic [NUM_BG-1:0][PIX_W-1:0]  hold_q, hold_d;
  logic [NUM_BG-1:0][PIX_W-1:0]  pix_q, pix_d;
  logic [NUM_BG-1:0][Y_W-1:0]    y_q, y_d;
  logic [Y_W:0]                  diff;
  logic [Y_W-1:0]                y_adj;

  // Borrow out of the wide subtract means the row would go negative.
  always_comb begin
    diff  = {1'b0, vcount}
          - {{(Y_W-3){1'b0}}, y_subtract};
    y_adj = diff[Y_W] ? '0 : diff[Y_W-1:0];
  end

  always_comb begin
    size_d = size_q;
    en_d   = en_q;
    hold_d = hold_q;
    pix_d  = pix_q;
    y_d    = y_q;
    if (reg_we) begin
      size_d = reg_wdata[7:4];
      en_d   = reg_wdata[NUM_BG-1:0];
    end
    if (dot_en) begin
      for (int i = 0; i < NUM_BG; i++) begin
        if (en_q[i] && !pixel_strobe)
          pix_d[i] = hold_q[i];
        else
          pix_d[i] = bg_pixel_in[i*PIX_W +: PIX_W];
        if (pixel_strobe)
          hold_d[i] = bg_pixel_in[i*PIX_W +: PIX_W];
        y_d[i] = en_q[i] ? y_adj : vcount;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      size_q <= '0;
      en_q   <= '0;
      hold_q <= '0;
      pix_q  <= '0;
      y_q    <= '0;
    end else begin
      size_q <= size_d;
      en_q   <= en_d;
      hold_q <= hold_d;
      pix_q  <= pix_d;
      y_q    <= y_d;
    end
  end

  assign size         = size_q;
  assign bg_pixel_out = pix_q;
  assign bg_y_out     = y_q;

`ifdef MOSAIC_READBACK_EN
  assign reg_rdata = {size_q, en_q};
`endif

endmodule

// File: tb/tb_bg_mosaic_apply.sv
// Bench for bg_mosaic_apply: directed tables, corner sequences and a
// randomized run against a per-dot behavioural model.
module tb_bg_mosaic_apply;

  logic        clk = 1'b0;
  logic        reset;
  logic        dot_en;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [3:0]  size;
  logic        pixel_strobe;
  logic [3:0]  y_subtract;
  logic [8:0]  vcount;
  logic [47:0] bg_pixel_in;
  logic [47:0] bg_pixel_out;
  logic [35:0] bg_y_out;
`ifdef MOSAIC_READBACK_EN
  logic [7:0]  reg_rdata;
`endif

  bg_mosaic_apply dut (
    .clk          (clk),
    .reset        (reset),
    .dot_en       (dot_en),
    .reg_we       (reg_we),
    .reg_wdata    (reg_wdata),
    .size         (size),
    .pixel_strobe (pixel_strobe),
    .y_subtract   (y_subtract),
    .vcount       (vcount),
    .bg_pixel_in  (bg_pixel_in),
    .bg_pixel_out (bg_pixel_out),
    .bg_y_out     (bg_y_out)
`ifdef MOSAIC_READBACK_EN
    ,
    .reg_rdata    (reg_rdata)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: per-BG register state, advanced once per clock.
  logic [3:0]  m_size;
  logic [3:0]  m_en;
  logic [11:0] m_hold [4];
  logic [11:0] m_out  [4];
  logic [8:0]  m_y    [4];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pbg(input logic [47:0] b, input int i);
    return b[i*12 +: 12];
  endfunction

  function automatic logic [8:0] ybg(input logic [35:0] b, input int i);
    return b[i*9 +: 9];
  endfunction

  function automatic logic [47:0] p4(input logic [11:0] a, input logic [11:0] b,
                                     input logic [11:0] c, input logic [11:0] d);
    return {d, c, b, a};
  endfunction

  task automatic model_clk();
    int d;
    logic [11:0] p;
    if (reset) begin
      m_size = 0;
      m_en = 0;
      for (int i = 0; i < 4; i++) begin
        m_hold[i] = 0; m_out[i] = 0; m_y[i] = 0;
      end
    end else begin
      if (dot_en) begin
        d = int'(vcount) - int'(y_subtract);
        if (d < 0) d = 0;
        for (int i = 0; i < 4; i++) begin
          p = pbg(bg_pixel_in, i);
          m_out[i] = (m_en[i] && !pixel_strobe) ? m_hold[i] : p;
          if (pixel_strobe) m_hold[i] = p;
          m_y[i] = m_en[i] ? 9'(d) : vcount;
        end
      end
      if (reg_we) begin
        m_size = reg_wdata[7:4];
        m_en = reg_wdata[3:0];
      end
    end
  endtask

  task automatic drive(input logic r, input logic de, input logic we,
                       input logic [7:0] wd, input logic st,
                       input logic [3:0] ys, input logic [8:0] vc,
                       input logic [47:0] pin);
    reset = r; dot_en = de; reg_we = we; reg_wdata = wd;
    pixel_strobe = st; y_subtract = ys; vcount = vc; bg_pixel_in = pin;
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic wr(input logic [7:0] wd);
    drive(0, 0, 1, wd, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic        st;
    logic [11:0] b1;
    logic [11:0] b2;
    logic [11:0] e1;
    logic [11:0] e2;
  } vec_t;

  vec_t tbl [8];
  logic [47:0] exp_p;
  logic [35:0] exp_y;

  initial begin
    for (int k = 0; k < 8; k++) begin
      tbl[k].st = (k == 0 || k == 4);
      tbl[k].b1 = 12'(10 + k);
      tbl[k].b2 = 12'(12'h100 + k);
      tbl[k].e1 = (k < 4) ? 12'd10 : 12'd14;
      tbl[k].e2 = 12'(12'h100 + k);
    end

    // reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    chk("reset_size", size, 0);
    chk("reset_pix", bg_pixel_out, 0);
    chk("reset_y", bg_y_out, 0);

    // size 0: passthrough with one-dot latency
    wr(8'h00);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, 0, 0, 1, 0, 9'(100 + k), p4(12'(k), 0, 0, 0));
      chk("pass_bg1", pbg(bg_pixel_out, 0), k);
      chk("pass_y", bg_y_out, {4{9'(100 + k)}});
    end

    // size 3, BG1 only
    wr(8'h31);
    chk("size3", size, 3);
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 0, 0, tbl[k].st, 0, 9'd30,
            p4(tbl[k].b1, tbl[k].b2, 0, 0));
      chk("blk_bg1", pbg(bg_pixel_out, 0), tbl[k].e1);
      chk("blk_bg2", pbg(bg_pixel_out, 1), tbl[k].e2);
    end

    // vertical subtract and saturation
    wr(8'hF5);
    drive(0, 1, 0, 0, 1, 6, 20, 0);
    chk("y_bg1", ybg(bg_y_out, 0), 14);
    chk("y_bg2", ybg(bg_y_out, 1), 20);
    chk("y_bg3", ybg(bg_y_out, 2), 14);
    chk("y_bg4", ybg(bg_y_out, 3), 20);
    drive(0, 1, 0, 0, 1, 9, 3, 0);
    chk("ysat_bg1", ybg(bg_y_out, 0), 0);
    chk("ysat_bg3", ybg(bg_y_out, 2), 0);
    chk("ysat_bg2", ybg(bg_y_out, 1), 3);

    // enable set/clear mid-block on BG2
    wr(8'h10);
    drive(0, 1, 0, 0, 1, 0, 0, p4(0, 12'h005, 0, 0));
    chk("en_latch", pbg(bg_pixel_out, 1), 12'h005);
    wr(8'h12);
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 0, 0, 0, 0, p4(0, 12'h009, 0, 0));
      chk("en_hold", pbg(bg_pixel_out, 1), 12'h005);
    end
    wr(8'h10);
    drive(0, 1, 0, 0, 0, 0, 0, p4(0, 12'h009, 0, 0));
    chk("en_clear", pbg(bg_pixel_out, 1), 12'h009);

    // write coincident with strobe, then a dot_en gap
    wr(8'h00);
    drive(0, 1, 1, 8'h31, 1, 2, 50, p4(12'h020, 0, 0, 0));
    chk("wrst_pix", pbg(bg_pixel_out, 0), 12'h020);
    chk("wrst_y_old", ybg(bg_y_out, 0), 50);
    drive(0, 0, 0, 0, 1, 2, 60, p4(12'h077, 0, 0, 0));
    chk("gap_pix", pbg(bg_pixel_out, 0), 12'h020);
    chk("gap_y", ybg(bg_y_out, 0), 50);
    drive(0, 1, 0, 0, 0, 2, 50, p4(12'h021, 0, 0, 0));
    chk("wrst_hold", pbg(bg_pixel_out, 0), 12'h020);
    chk("wrst_y_new", ybg(bg_y_out, 0), 48);

    // reset mid-block
    wr(8'h7F);
    drive(0, 1, 0, 0, 1, 3, 40, {4{12'h0AA}});
    drive(0, 1, 0, 0, 0, 3, 40, {4{12'h0BB}});
    chk("pre_rst", bg_pixel_out, {4{12'h0AA}});
    drive(1, 1, 0, 0, 0, 3, 40, {4{12'h0CC}});
    chk("mrst_size", size, 0);
    chk("mrst_pix", bg_pixel_out, 0);
    chk("mrst_y", bg_y_out, 0);
    drive(0, 1, 0, 0, 0, 3, 7, {4{12'h033}});
    chk("post_rst_pix", bg_pixel_out, {4{12'h033}});
    chk("post_rst_y", bg_y_out, {4{9'd7}});

`ifdef MOSAIC_READBACK_EN
    wr(8'hA3);
    chk("readback", reg_rdata, 8'hA3);
`endif

    // randomized run against the model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0),
            8'($urandom),
            ($urandom_range(0, 2) == 0),
            4'($urandom),
            9'($urandom),
            {16'($urandom), 32'($urandom)});
      for (int i = 0; i < 4; i++) begin
        exp_p[i*12 +: 12] = m_out[i];
        exp_y[i*9 +: 9] = m_y[i];
      end
      chk("rnd_size", size, m_size);
      chk("rnd_pix", bg_pixel_out, exp_p);
      chk("rnd_y", bg_y_out, exp_y);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
